// File: rtl/lfsr_pkg.sv
// Shared types and default widths for the LFSR burst streamer.
package lfsr_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LEN_WIDTH  = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PRIME = 3'd2,
    S_SKIP  = 3'd3,
    S_RUN   = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

endpackage

// File: rtl/fibonacci_lfsr.sv
// Free-running Fibonacci LFSR: shifts right, feedback (parity of state & tap)
// enters at the MSB. While resetn is low it captures din/tap and presents 1;
// the first cycle after release it presents din, then steps every cycle.
module fibonacci_lfsr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] din,
  input  logic [W-1:0] tap,
  output logic [W-1:0] dout
);

  logic [W-1:0] r_state;
  logic [W-1:0] r_seed;
  logic [W-1:0] r_tap;
  logic         r_ld;

  // Load on reset, move seed into the state one cycle later, then step.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= W'(1);
      r_seed  <= din;
      r_tap   <= tap;
      r_ld    <= 1'b1;
    end else if (r_ld) begin
      r_state <= r_seed;
      r_ld    <= 1'b0;
    end else begin
      r_state <= {^(r_state & r_tap), r_state[W-1:1]};
    end
  end

  assign dout = r_state;

endmodule

// File: rtl/lfsr_stream_ctrl.sv
// Burst controller that streams LFSR words over a valid/ready interface.
// The LFSR cannot stall, so backpressure parks the word in a hold register
// and the LFSR is later reseeded from it; the SKIP state drops the duplicate
// (the reseeded LFSR first re-presents the already-accepted word).
module lfsr_stream_ctrl
  import lfsr_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  input  logic [DATA_WIDTH-1:0] cfg_tap,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err_zero_seed
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_seed;
  logic [DATA_WIDTH-1:0] r_tap;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_resume;
  logic                  r_done;
  logic                  r_err;

  logic [DATA_WIDTH-1:0] w_dout;
  logic                  w_lfsr_rstn;
  logic                  w_valid;
  logic                  w_fire;
  logic                  w_last;
  logic                  w_done_set;
  logic                  w_err_set;

  // LFSR is loaded only in LOAD, and held in load under module reset.
  assign w_lfsr_rstn = resetn && (r_state != S_LOAD);

  fibonacci_lfsr #(.W(DATA_WIDTH)) u_lfsr (
    .clk    (clk),
    .resetn (w_lfsr_rstn),
    .din    (r_seed),
    .tap    (r_tap),
    .dout   (w_dout)
  );

  assign w_valid = (r_state == S_RUN) || (r_state == S_HOLD);
  assign w_fire  = w_valid && out_ready;
  assign w_last  = (r_cnt == r_len - LEN_WIDTH'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and one-cycle event decode.
  always_comb begin
    w_state_nxt = r_state;
    w_done_set  = 1'b0;
    w_err_set   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cfg_valid) begin
          if (cfg_seed == '0)     w_err_set   = 1'b1;
          else if (cfg_len == '0) w_done_set  = 1'b1;
          else                    w_state_nxt = S_LOAD;
        end
      end
      S_LOAD:  w_state_nxt = S_PRIME;
      S_PRIME: w_state_nxt = r_resume ? S_SKIP : S_RUN;
      S_SKIP:  w_state_nxt = S_RUN;
      S_RUN: begin
        if (!out_ready) w_state_nxt = S_HOLD;
        else if (w_last) begin
          w_state_nxt = S_IDLE;
          w_done_set  = 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_done_set  = 1'b1;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Config latch, word counter, hold register and event pulses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_seed   <= '0;
      r_tap    <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_hold   <= '0;
      r_resume <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= w_done_set;
      r_err  <= w_err_set;
      if (r_state == S_IDLE && cfg_valid) begin
        r_seed   <= cfg_seed;
        r_tap    <= cfg_tap;
        r_len    <= cfg_len;
        r_cnt    <= '0;
        r_resume <= 1'b0;
      end
      if (r_state == S_RUN && !out_ready) r_hold <= w_dout;
      if (w_fire) r_cnt <= r_cnt + LEN_WIDTH'(1);
      if (r_state == S_HOLD && out_ready && !w_last) begin
        r_seed   <= r_hold;
        r_resume <= 1'b1;
      end
    end
  end

  // All outputs read as zero while reset is asserted.
  assign out_valid     = resetn && w_valid;
  assign out_data      = !out_valid ? '0 : (r_state == S_HOLD) ? r_hold : w_dout;
  assign out_last      = out_valid && w_last;
  assign busy          = resetn && (r_state != S_IDLE);
  assign cfg_ready     = resetn && (r_state == S_IDLE);
  assign done          = resetn && r_done;
  assign err_zero_seed = resetn && r_err;

endmodule

// File: tb/tb_lfsr_stream_ctrl.sv
// Directed bench for lfsr_stream_ctrl: basic burst, backpressure resume,
// zero seed, zero length, mid-burst reset, and a long randomized-ready burst.
module tb_lfsr_stream_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_seed;
  logic [7:0]  cfg_tap;
  logic [15:0] cfg_len;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err_zero_seed;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lfsr_stream_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_seed      (cfg_seed),
    .cfg_tap       (cfg_tap),
    .cfg_len       (cfg_len),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
    .err_zero_seed (err_zero_seed)
  );

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lstep(input logic [7:0] s, input logic [7:0] t);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < 8; i++) fb = fb ^ (s[i] & t[i]);
    return {fb, s[7:1]};
  endfunction

  logic [7:0] exp1 [5] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10};
  logic [7:0] model;
  int         n;
  int         cyc;

  initial begin
    resetn = 1'b0; cfg_valid = 1'b0; cfg_seed = '0; cfg_tap = '0; cfg_len = '0;
    out_ready = 1'b0;
    nxt(); nxt(); #1;
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_zero_seed, 0);
    nxt(); resetn = 1'b1; #1;
    chk("rel_cfg_ready", cfg_ready, 1);
    chk("rel_busy", busy, 0);

    // Basic burst, plus a would-be-error request while busy (must be ignored).
    nxt(); cfg_valid = 1; cfg_seed = 8'h01; cfg_tap = 8'h1D; cfg_len = 5; out_ready = 1; #1;
    chk("b1_ready", cfg_ready, 1);
    nxt(); cfg_seed = 8'h00; cfg_len = 0; #1;
    chk("b1_load_busy", busy, 1);
    chk("b1_load_valid", out_valid, 0);
    chk("b1_load_ready", cfg_ready, 0);
    nxt(); cfg_valid = 0; #1;
    chk("b1_prime_valid", out_valid, 0);
    chk("b1_busy_cfg_ignored", err_zero_seed, 0);
    for (int i = 0; i < 5; i++) begin
      nxt(); #1;
      chk("b1_valid", out_valid, 1);
      chk("b1_data", out_data, exp1[i]);
      chk("b1_last", out_last, (i == 4));
    end
    nxt(); #1;
    chk("b1_done", done, 1);
    chk("b1_idle_busy", busy, 0);
    chk("b1_idle_valid", out_valid, 0);
    nxt(); #1;
    chk("b1_done_pulse", done, 0);

    // Backpressure on the third word, resume with a 3-cycle bubble.
    nxt(); cfg_valid = 1; cfg_seed = 8'h01; cfg_tap = 8'h1D; cfg_len = 4; out_ready = 1; #1;
    nxt(); cfg_valid = 0; #1;
    nxt(); #1;
    nxt(); #1; chk("b2_w0", out_data, 8'h01); chk("b2_w0_last", out_last, 0);
    nxt(); #1; chk("b2_w1", out_data, 8'h80);
    nxt(); out_ready = 0; #1;
    chk("b2_w2_valid", out_valid, 1); chk("b2_w2", out_data, 8'h40);
    nxt(); #1;
    chk("b2_hold_valid", out_valid, 1); chk("b2_hold_data", out_data, 8'h40);
    nxt(); out_ready = 1; #1;
    chk("b2_hold2_data", out_data, 8'h40); chk("b2_hold2_last", out_last, 0);
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk("b2_bubble_valid", out_valid, 0);
      chk("b2_bubble_busy", busy, 1);
    end
    nxt(); #1;
    chk("b2_w3_valid", out_valid, 1); chk("b2_w3", out_data, 8'h20);
    chk("b2_w3_last", out_last, 1);
    nxt(); #1;
    chk("b2_done", done, 1); chk("b2_valid_after", out_valid, 0);

    // Zero seed is rejected with an error pulse.
    nxt(); cfg_valid = 1; cfg_seed = 8'h00; cfg_len = 3; #1;
    chk("zs_ready", cfg_ready, 1);
    nxt(); cfg_valid = 0; #1;
    chk("zs_err", err_zero_seed, 1);
    chk("zs_valid", out_valid, 0);
    chk("zs_ready_after", cfg_ready, 1);
    chk("zs_no_done", done, 0);
    nxt(); #1;
    chk("zs_err_pulse", err_zero_seed, 0);
    chk("zs_valid2", out_valid, 0);

    // Zero length completes immediately.
    nxt(); cfg_valid = 1; cfg_seed = 8'h01; cfg_len = 0; #1;
    nxt(); cfg_valid = 0; #1;
    chk("zl_done", done, 1); chk("zl_valid", out_valid, 0); chk("zl_busy", busy, 0);
    chk("zl_err", err_zero_seed, 0);
    nxt(); #1;
    chk("zl_done_pulse", done, 0);

    // Reset during the third word abandons the burst.
    nxt(); cfg_valid = 1; cfg_seed = 8'h01; cfg_tap = 8'h1D; cfg_len = 5; out_ready = 1; #1;
    nxt(); cfg_valid = 0; #1;
    nxt(); #1;
    nxt(); #1; chk("mr_w0", out_data, 8'h01);
    nxt(); #1; chk("mr_w1", out_data, 8'h80);
    nxt(); resetn = 0; #1;
    chk("mr_valid", out_valid, 0); chk("mr_data", out_data, 0);
    chk("mr_last", out_last, 0); chk("mr_busy", busy, 0);
    chk("mr_ready", cfg_ready, 0); chk("mr_done", done, 0);
    nxt(); resetn = 1; cfg_valid = 1; cfg_seed = 8'h10; cfg_tap = 8'h1D; cfg_len = 2; #1;
    chk("mr_ready_back", cfg_ready, 1); chk("mr_no_done", done, 0); chk("mr_idle", busy, 0);
    nxt(); cfg_valid = 0; #1;
    chk("mr_no_done2", done, 0);
    nxt(); #1;
    nxt(); #1; chk("mr_n0", out_data, 8'h10); chk("mr_n0_last", out_last, 0);
    nxt(); #1; chk("mr_n1", out_data, 8'h88); chk("mr_n1_last", out_last, 1);
    nxt(); #1; chk("mr_n_done", done, 1);

    // Long burst with random backpressure against a free-running model.
    nxt(); cfg_valid = 1; cfg_seed = 8'hA5; cfg_tap = 8'h1D; cfg_len = 200; out_ready = 1; #1;
    nxt(); cfg_valid = 0; #1;
    model = 8'hA5; n = 0; cyc = 0;
    while (n < 200 && cyc < 5000) begin
      nxt(); out_ready = 1'($urandom_range(0, 1)); #1;
      cyc++;
      if (out_valid) begin
        chk("rnd_data", out_data, model);
        chk("rnd_last", out_last, (n == 199));
        if (out_ready) begin
          model = lstep(model, 8'h1D);
          n++;
        end
      end
    end
    chk("rnd_accepts", n, 200);
    nxt(); out_ready = 1; #1;
    chk("rnd_done", done, 1);
    chk("rnd_valid_after", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_stream_ctrl.md
LFSR_STREAM_CTRL -- requirements
Module: lfsr_stream_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, LFSR state/word width.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, width of the burst-length field.
REQ-003 SHALL have port clk  input  1  clock; reset resetn, synchronous, active-low; clock clk.
REQ-004 SHALL have port resetn  input  1  synchronous active-low reset.
REQ-005 SHALL have port cfg_valid  input  1  burst request.
REQ-006 SHALL have port cfg_ready  output  1  controller idle, request is accepted this cycle.
REQ-007 SHALL have port cfg_seed  input  DATA_WIDTH  initial LFSR state.
REQ-008 SHALL have port cfg_tap  input  DATA_WIDTH  feedback tap mask.
REQ-009 SHALL have port cfg_len  input  LEN_WIDTH  number of words to emit.
REQ-010 SHALL have port out_valid  output  1  out_data valid.
REQ-011 SHALL have port out_ready  input  1  sink accepts the word.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  LFSR word.
REQ-013 SHALL have port out_last  output  1  final word of the burst, qualified by out_valid.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the last accept, or after a zero-length accept.
REQ-016 SHALL have port err_zero_seed  output  1  one-cycle pulse when a request with cfg_seed==0 is rejected.

Function
REQ-017 SHALL instantiate one fibonacci_lfsr and drive its resetn low for exactly one cycle (state LOAD) to load din=seed and tap=tap; that resetn SHALL also be low whenever the module resetn is low.
REQ-018 SHALL rely on these LFSR timing facts: load in cycle L gives dout=1 at L+1 and dout=seed at L+2; dout then advances one step every cycle and cannot be stalled.
REQ-019 SHALL implement FSM states IDLE, LOAD, PRIME, SKIP, RUN and HOLD.
REQ-020 IDLE: cfg_ready=1; on cfg_valid the controller SHALL latch seed, tap and len.
REQ-021 In IDLE with seed==0, the request SHALL be consumed, err_zero_seed SHALL pulse, and the FSM SHALL stay in IDLE.
REQ-022 In IDLE with len==0 and seed!=0, done SHALL pulse next cycle and the FSM SHALL stay in IDLE.
REQ-023 In IDLE with a valid request, the FSM SHALL go to LOAD and clear the word counter.
REQ-024 The FSM SHALL sequence LOAD -> PRIME -> RUN for a fresh burst, and LOAD -> PRIME -> SKIP -> RUN for a resume; SKIP SHALL discard the duplicate word.
REQ-025 RUN: out_valid=1 and out_data=lfsr dout; on accept the counter SHALL increment.
REQ-026 RUN with out_ready=0: the controller SHALL capture dout into hold_q and go to HOLD.
REQ-027 HOLD: out_valid=1 and out_data=hold_q, stable until accepted; on accept of a non-last word, seed SHALL be set to hold_q and the FSM SHALL go to LOAD (resume, 3-cycle bubble).
REQ-028 out_last SHALL equal (counter==len-1) while out_valid=1.
REQ-029 On accept of the last word, the FSM SHALL go to IDLE and done SHALL pulse next cycle.
REQ-030 out_valid SHALL be 0 in IDLE, LOAD, PRIME and SKIP.
REQ-031 The emitted stream SHALL equal the uninterrupted LFSR sequence from seed regardless of backpressure pattern.
REQ-032 The counter SHALL be LEN_WIDTH bits; len up to 2^LEN_WIDTH-1 SHALL be supported with no wrap inside a burst.
REQ-033 cfg inputs SHALL be ignored while busy=1.

Reset
REQ-034 resetn low SHALL force IDLE, counter=0, hold_q=0, latched seed/tap/len=0, and hold the LFSR in load.
REQ-035 While resetn is low, outputs SHALL be: out_valid=0, out_last=0, out_data=0, done=0, err_zero_seed=0, busy=0, cfg_ready=0.
REQ-036 Reset asserted mid-burst SHALL abandon the burst without a done pulse; cfg_ready=1 SHALL return the cycle after resetn deasserts.

Structure
REQ-037 A shared package lfsr_pkg SHALL hold the FSM state enum and the default DATA_WIDTH/LEN_WIDTH constants.
REQ-038 fibonacci_lfsr SHALL be the only sub-module; the controller SHALL not duplicate the LFSR step logic.

Verification
REQ-039 seed=8'h01, tap=8'h1D, len=5, out_ready=1 -> 01,80,40,20,10; out_last on 10; first valid 2 cycles after accept; done 1 cycle after.
REQ-040 Same config, len=4, out_ready=0 for 2 cycles when 40 is presented -> 40 held stable; stream 01,80,40,20; 3-cycle bubble after 40; out_last on 20.
REQ-041 out_ready randomly toggled, len=200 -> output matches a golden model of uninterrupted LFSR steps; exactly 200 accepts.
REQ-042 cfg_seed=0, cfg_valid=1 -> err_zero_seed pulse, out_valid never asserted, cfg_ready stays 1.
REQ-043 len=0 -> done pulse, no out_valid.
REQ-044 resetn low for 1 cycle mid-burst (3rd word) -> all outputs at reset values, no done; a new burst seed=8'h10 then yields 10,88 first.
